unpacked_inst_serializer: RTL
=============================

Name: unpacked_inst_serializer

Overview:
- Reader-side counterpart to an interface-held unpacked array that is written via `always_ff`/`foreach`.
- Captures a full N-entry unpacked array into an unpacked array member of an internal interface instance.
- Streams the entries out one per handshake, index 0 first, with valid/ready/last.
- Sits between a parallel producer and a narrow serial consumer.

Parameters:
- N, 8, number of array entries; must be at least 2.
- W, 4, width of each entry in bits.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  reset; synchronous and active-high.
- i_load  input  1  request to capture i_data.
- i_data  input  W x [N] unpacked  parallel entries to capture.
- o_busy  output  1  high while streaming; a load is accepted only when low, or on the final-beat handshake cycle.
- o_valid  output  1  o_data holds a valid entry.
- i_ready  input  1  consumer accepts the current beat.
- o_data  output  W  current entry, x[idx].
- o_last  output  1  current beat is entry N-1.

Behaviour:
- Storage
  - Interface instance u_I of interface I #(N, W) holds member `logic [W-1:0] x [N]`.
  - All writes to u_I.x happen in one `always_ff` using a foreach over u_I.x[i].
- State
  - Two states: IDLE and STREAM.
  - Index register idx has width $clog2(N).
- Reset (i_rst high at a rising edge)
  - State becomes IDLE and idx becomes 0.
  - Every u_I.x[i] becomes 0.
  - Resulting outputs: o_valid=0, o_busy=0, o_last=0, o_data=0.
  - Reset takes priority over every other event, including mid-stream: the stream is abandoned and no further beats are produced.
- Load acceptance
  - Load is accepted when i_load=1 and either:
    - state is IDLE, or
    - state is STREAM, idx=N-1, and i_ready=1 (final-beat handshake).
  - On acceptance:
    - u_I.x[i] <= i_data[i] for all i;
    - idx <= 0;
    - state <= STREAM.
  - Latency: first beat is valid on the cycle after acceptance.
  - i_load in STREAM outside the final-beat handshake is ignored. u_I.x and idx are unchanged.
- Outputs (combinational from state and idx)
  - o_valid = o_busy = (state == STREAM).
  - o_data = u_I.x[idx], regardless of o_valid.
  - o_last = o_valid && (idx == N-1).
- Handshake
  - A beat transfers when o_valid && i_ready.
  - On a transfer with idx < N-1: idx increments by 1.
  - On a transfer with idx == N-1:
    - with a load accepted in the same cycle: state stays STREAM and idx goes to 0, giving back-to-back frames with no bubble;
    - otherwise: state goes to IDLE and idx goes to 0.
  - With i_ready=0, o_data, o_last and idx hold stable.
  - The producer must not change u_I.x content mid-frame. The design enforces this through the acceptance rule above.
- Wrap-around
  - idx never exceeds N-1.
  - For N not a power of two, idx compares against N-1 explicitly and does not rely on natural overflow.
- Throughput
  - N beats per frame with i_ready held high.
  - One frame every N cycles with back-to-back loads.

Decomposition:
- Package unpacked_inst_serializer_pkg contains:
  - typedef enum logic {IDLE, STREAM} state_t;
  - a localparam function idx_w(N) = (N > 1) ? $clog2(N) : 1.
- Interface I #(N, W) is the storage container and is declared beside the module.
- No further sub-module; the control path is a single FSM plus index counter.

Test Plan:
- Reset: assert i_rst for 2 cycles with i_load=1 and i_data all 4'hF -> o_valid=0, o_busy=0, o_last=0, o_data=0; no capture occurs.
- Basic stream: in IDLE, pulse i_load with i_data[i]=i (0..7), i_ready held 1 -> beats 0,1,...,7 on 8 consecutive cycles starting the cycle after load; o_last=1 only on beat 7; o_valid=0 the cycle after.
- Backpressure: same frame, i_ready=0 during beats 2 and 5 for 3 cycles each -> o_data stays 2 and then 5 while stalled; sequence and o_last unchanged; total 14 valid cycles.
- Ignored load: mid-frame at idx=3, pulse i_load with i_data all 4'hA -> remaining beats still 3..7; o_busy=1 throughout; back in IDLE afterwards.
- Back-to-back: at the beat-7 handshake, load i_data[i]=7-i -> the next cycle shows o_valid=1 and o_data=7; no bubble; second frame reads 7..0.
- Reset mid-operation: i_rst at idx=4 -> next cycle o_valid=0 and o_data=0; a new load afterwards streams from entry 0.

Source files
------------

// File: rtl/unpacked_inst_serializer_pkg.sv
// unpacked_inst_serializer_pkg: shared state type and index-width helper
package unpacked_inst_serializer_pkg;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/unpacked_inst_serializer.sv
// unpacked_inst_serializer: captures an N-entry array into interface storage and streams it out with valid/ready/last
interface I #(
  parameter int N = 8,
  parameter int W = 4
);
  logic [W-1:0] x [N];
endinterface

module unpacked_inst_serializer
  import unpacked_inst_serializer_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data [N],
  output logic         o_busy,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_last
);
  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  I #(.N(N), .W(W)) u_I ();
  state_t state;
  logic [IW-1:0] idx;
  logic fire, at_last, accept;
  assign at_last = idx == LAST;
  assign fire = o_valid && i_ready;
  assign accept = i_load && (state == IDLE || (fire && at_last));
  assign o_valid = state == STREAM;
  assign o_busy = o_valid;
  assign o_last = o_valid && at_last;
  assign o_data = u_I.x[idx];
  // frame storage: cleared on reset, refilled only when a load is accepted
  always_ff @(posedge i_clk) begin
    foreach (u_I.x[i]) begin
      if (i_rst) u_I.x[i] <= '0;
      else if (accept) u_I.x[i] <= i_data[i];
    end
  end
  // control FSM and beat index; idx compares against N-1 so non power-of-two N wraps correctly
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      idx <= '0;
    end else if (accept) begin
      state <= STREAM;
      idx <= '0;
    end else if (fire) begin
      state <= at_last ? IDLE : STREAM;
      idx <= at_last ? '0 : idx + 1'b1;
    end
  end
endmodule
